// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_pkg : shared encodings for the i2c init sequencer (ops, error codes,   |
// |           table-entry field positions, state encoding)                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [1:0] {
    OP_END   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READV = 2'b10,
    OP_DELAY = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_REQ    = 4'd3,
    S_WAIT   = 4'd4,
    S_GAP    = 4'd5,
    S_DLY    = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_e;

  localparam logic [2:0] c_err_nack_slave = 3'd1;
  localparam logic [2:0] c_err_nack_addr  = 3'd2;
  localparam logic [2:0] c_err_nack_data  = 3'd3;
  localparam logic [2:0] c_err_verify     = 3'd4;
  localparam logic [2:0] c_err_ack_tmo    = 3'd5;
  localparam logic [2:0] c_err_bad_op     = 3'd6;

  localparam int c_op_lsb  = 30;
  localparam int c_rsv_lsb = 23;
  localparam int c_slv_lsb = 16;
  localparam int c_reg_lsb = 8;
  localparam int c_dat_lsb = 0;

  // Lowest set NACK bit wins: slave before addr before data.
  function automatic logic [2:0] nack_code(input logic [2:0] nack);
    if (nack[0]) return c_err_nack_slave;
    if (nack[1]) return c_err_nack_addr;
    return c_err_nack_data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_seq_timer : down-counter shared by ack-timeout, retry gap and delay    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module i2c_seq_timer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Loading N keeps the owning state resident for N+1 clocks.
  assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/i2c_init_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_init_seq : table-driven command sequencer in front of i2c_master       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter int TBL_AW     = 6,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_GAP  = 1000,
  parameter int DELAY_UNIT = 1000,
  parameter int ACK_TMO    = 255
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_err_code,
  output logic [TBL_AW-1:0] o_err_idx,
  output logic [TBL_AW-1:0] o_tbl_addr,
  input  logic [31:0]       i_tbl_data,
  output logic              o_m_wr,
  output logic              o_m_rd,
  output logic [6:0]        o_m_slave,
  output logic [7:0]        o_m_reg,
  output logic [7:0]        o_m_wdata,
  input  logic [7:0]        i_m_rdata,
  input  logic              i_m_busy,
  input  logic              i_m_rvalid,
  input  logic [2:0]        i_m_nack
);

  localparam logic [7:0]  c_max_retry = 8'(MAX_RETRY);
  localparam logic [31:0] c_ack_load  = 32'(ACK_TMO - 1);
  localparam logic [31:0] c_gap_load  = 32'(RETRY_GAP - 1);

  state_e            r_state, w_state_nxt;
  logic [TBL_AW-1:0] r_idx, r_err_idx;
  op_e               r_op;
  logic [6:0]        r_slave;
  logic [7:0]        r_reg, r_data, r_rdata, r_retry;
  logic              r_busy_q, r_rv_seen, r_done, r_err;
  logic [2:0]        r_err_code;

  op_e         w_op;
  logic [6:0]  w_rsv;
  logic [15:0] w_ticks;
  logic        w_fall, w_rv, w_tmr_done, w_tmr_load, w_adv;
  logic [7:0]  w_rd_byte;
  logic [31:0] w_tmr_val;
  logic        w_idx_inc, w_retry_clr, w_retry_inc, w_set_done, w_set_err, w_start_ok;
  logic [2:0]  w_err_code;

  assign w_op      = op_e'(i_tbl_data[c_op_lsb +: 2]);
  assign w_rsv     = i_tbl_data[c_rsv_lsb +: 7];
  assign w_ticks   = i_tbl_data[15:0];
  assign w_fall    = r_busy_q & ~i_m_busy;
  // Read data may arrive on the same clock the master drops busy.
  assign w_rv      = r_rv_seen | i_m_rvalid;
  assign w_rd_byte = i_m_rvalid ? i_m_rdata : r_rdata;

  i2c_seq_timer #(.WIDTH(32)) u_timer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_done (w_tmr_done)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_adv       = 1'b0;
    w_idx_inc   = 1'b0;
    w_retry_clr = 1'b0;
    w_retry_inc = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    w_err_code  = '0;
    w_start_ok  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_state_nxt = S_FETCH;
          w_start_ok  = 1'b1;
        end
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_rsv != '0) begin
          w_state_nxt = S_ERROR;
          w_set_err   = 1'b1;
          w_err_code  = c_err_bad_op;
        end else begin
          case (w_op)
            OP_END: begin
              w_state_nxt = S_DONE;
              w_set_done  = 1'b1;
            end
            OP_WRITE, OP_READV: begin
              w_state_nxt = S_REQ;
              w_retry_clr = 1'b1;
              w_tmr_load  = 1'b1;
              w_tmr_val   = c_ack_load;
            end
            default: begin
              if (w_ticks == '0) begin
                w_adv = 1'b1;
              end else begin
                w_state_nxt = S_DLY;
                w_tmr_load  = 1'b1;
                w_tmr_val   = 32'(w_ticks) * 32'(DELAY_UNIT) - 32'd1;
              end
            end
          endcase
        end
      end
      S_REQ: begin
        if (i_m_busy) begin
          w_state_nxt = S_WAIT;
        end else if (w_tmr_done) begin
          w_state_nxt = S_ERROR;
          w_set_err   = 1'b1;
          w_err_code  = c_err_ack_tmo;
        end
      end
      S_WAIT: begin
        if (w_fall) begin
          if (|i_m_nack) begin
            if (r_retry < c_max_retry) begin
              w_state_nxt = S_GAP;
              w_retry_inc = 1'b1;
              w_tmr_load  = 1'b1;
              w_tmr_val   = c_gap_load;
            end else begin
              w_state_nxt = S_ERROR;
              w_set_err   = 1'b1;
              w_err_code  = nack_code(i_m_nack);
            end
          end else if (r_op == OP_READV && (!w_rv || w_rd_byte != r_data)) begin
            w_state_nxt = S_ERROR;
            w_set_err   = 1'b1;
            w_err_code  = c_err_verify;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_tmr_done) begin
          w_state_nxt = S_REQ;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_ack_load;
        end
      end
      S_DLY: if (w_tmr_done) w_adv = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
    // Finishing the last table slot ends the run instead of wrapping to 0.
    if (w_adv) begin
      if (&r_idx) begin
        w_state_nxt = S_DONE;
        w_set_done  = 1'b1;
      end else begin
        w_state_nxt = S_FETCH;
        w_idx_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_idx      <= '0;
      r_err_idx  <= '0;
      r_op       <= OP_END;
      r_slave    <= '0;
      r_reg      <= '0;
      r_data     <= '0;
      r_rdata    <= '0;
      r_retry    <= '0;
      r_busy_q   <= 1'b0;
      r_rv_seen  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_busy_q <= i_m_busy;
      if (w_start_ok) begin
        r_idx      <= '0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= '0;
        r_err_idx  <= '0;
      end
      if (w_idx_inc) r_idx <= r_idx + 1'b1;
      if (r_state == S_DECODE) begin
        r_op    <= w_op;
        r_slave <= i_tbl_data[c_slv_lsb +: 7];
        r_reg   <= i_tbl_data[c_reg_lsb +: 8];
        r_data  <= i_tbl_data[c_dat_lsb +: 8];
      end
      if (w_retry_clr)      r_retry <= '0;
      else if (w_retry_inc) r_retry <= r_retry + 1'b1;
      if (r_state == S_REQ) begin
        r_rv_seen <= 1'b0;
      end else if (i_m_rvalid) begin
        r_rv_seen <= 1'b1;
        r_rdata   <= i_m_rdata;
      end
      if (w_set_done) r_done <= 1'b1;
      if (w_set_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
        r_err_idx  <= r_idx;
      end
    end
  end

  assign o_busy     = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;
  assign o_err_idx  = r_err_idx;
  assign o_tbl_addr = r_idx;
  assign o_m_wr     = (r_state == S_REQ) && (r_op == OP_WRITE);
  assign o_m_rd     = (r_state == S_REQ) && (r_op == OP_READV);
  assign o_m_slave  = r_slave;
  assign o_m_reg    = r_reg;
  assign o_m_wdata  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2c_init_seq : scoreboard bench with a behavioural i2c_master model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_i2c_init_seq;

  localparam int TBL_AW     = 4;
  localparam int MAX_RETRY  = 3;
  localparam int RETRY_GAP  = 8;
  localparam int DELAY_UNIT = 4;
  localparam int ACK_TMO    = 255;
  // Busy-fall to next request edge: fall seen, fetch, decode, request.
  localparam int B2B        = 4;

  logic        clk = 1'b0;
  logic        rstn, start;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic [3:0]  err_idx, tbl_addr;
  logic [31:0] tbl_data;
  logic        m_wr, m_rd;
  logic [6:0]  m_slave;
  logic [7:0]  m_reg, m_wdata, m_rdata;
  logic        m_busy, m_rvalid;
  logic [2:0]  m_nack;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] tbl [0:15];
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  i2c_init_seq #(
    .TBL_AW(TBL_AW), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP),
    .DELAY_UNIT(DELAY_UNIT), .ACK_TMO(ACK_TMO)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_err_code(err_code), .o_err_idx(err_idx),
    .o_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
    .o_m_wr(m_wr), .o_m_rd(m_rd), .o_m_slave(m_slave),
    .o_m_reg(m_reg), .o_m_wdata(m_wdata), .i_m_rdata(m_rdata),
    .i_m_busy(m_busy), .i_m_rvalid(m_rvalid), .i_m_nack(m_nack)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Master model knobs, driven from the stimulus block between runs.
  int         blen = 6;
  bit         no_busy = 1'b0;
  logic [7:0] rd_val = 8'h00;
  int         nack_from = 0, nack_cnt = 0;
  logic [2:0] nack_val = 3'b000;

  int          req_n = 0;
  int          last_fall = 0;
  int          m_cnt;
  logic        m_is_rd;
  logic [24:0] exp_q[$];
  int          gaps[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      m_rvalid <= 1'b0;
      m_nack   <= 3'b000;
      m_rdata  <= 8'h00;
      m_is_rd  <= 1'b0;
    end else begin
      m_rvalid <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_rvalid <= m_is_rd;
          m_rdata  <= rd_val;
        end
        if (m_cnt == 0) begin
          m_busy    <= 1'b0;
          last_fall <= cyc;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if ((m_wr || m_rd) && !no_busy) begin
        m_busy  <= 1'b1;
        m_cnt   <= blen;
        m_is_rd <= m_rd;
        m_nack  <= (req_n >= nack_from && req_n < nack_from + nack_cnt) ? nack_val : 3'b000;
        req_n   <= req_n + 1;
        gaps.push_back(cyc - last_fall);
        check("wr_rd_excl", 32'(m_wr & m_rd), 32'd0);
        if (exp_q.size() == 0)
          check("unexpected_req", 32'({m_rd, m_wr, m_slave, m_reg, m_wdata}), 32'd0);
        else
          check("req", 32'({m_rd, m_wr, m_slave, m_reg, m_wdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [31:0] ent(input logic [1:0] op, input logic [6:0] s,
                                      input logic [7:0] r, input logic [7:0] d);
    return {op, 7'd0, s, r, d};
  endfunction

  task automatic expw(input logic [6:0] s, input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back({2'b01, s, r, d});
  endtask

  task automatic expr(input logic [6:0] s, input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back({2'b10, s, r, d});
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 16; i++) tbl[i] = 32'h0;
    gaps.delete();
  endtask

  task automatic run(input int budget, output int el);
    int t0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
    el = cyc - t0;
    check("finished", 32'(done | err), 32'd1);
  endtask

  int el;

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    clear_tbl();
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({busy, done, err, err_code, err_idx, tbl_addr, m_wr, m_rd}), 32'd0);
    check("rst_bus", 32'({m_slave, m_reg, m_wdata}), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // T1: two writes then END
    clear_tbl();
    tbl[0] = ent(2'b01, 7'h3C, 8'h10, 8'hA5);
    tbl[1] = ent(2'b01, 7'h3C, 8'h11, 8'h5A);
    expw(7'h3C, 8'h10, 8'hA5);
    expw(7'h3C, 8'h11, 8'h5A);
    run(300, el);
    check("t1_status", 32'({busy, err, done}), 32'b001);
    check("t1_q_empty", exp_q.size(), 0);
    check("t1_b2b_gap", gaps[1], B2B);

    // T2: read-verify match, then mismatch
    clear_tbl();
    tbl[0] = ent(2'b10, 7'h3C, 8'h20, 8'h77);
    rd_val = 8'h77;
    expr(7'h3C, 8'h20, 8'h77);
    run(300, el);
    check("t2_match", 32'({busy, err, done}), 32'b001);
    rd_val = 8'h76;
    expr(7'h3C, 8'h20, 8'h77);
    run(300, el);
    check("t2_mismatch", 32'({busy, err, done, err_code, err_idx}), {25'd0, 3'b010, 3'd4, 4'd0});

    // T3: NACK retries on entry 1
    clear_tbl();
    tbl[0] = ent(2'b01, 7'h3C, 8'h01, 8'h11);
    tbl[1] = ent(2'b01, 7'h3C, 8'h02, 8'h22);
    nack_from = req_n + 1; nack_cnt = 2; nack_val = 3'b001;
    expw(7'h3C, 8'h01, 8'h11);
    repeat (3) expw(7'h3C, 8'h02, 8'h22);
    run(500, el);
    check("t3_retry_ok", 32'({busy, err, done}), 32'b001);
    check("t3_nreq", gaps.size(), 4);
    check("t3_gap_a", gaps[2], RETRY_GAP + 2);
    check("t3_gap_b", gaps[3], RETRY_GAP + 2);
    check("t3_q_empty", exp_q.size(), 0);

    gaps.delete();
    nack_from = req_n + 1; nack_cnt = 100; nack_val = 3'b001;
    expw(7'h3C, 8'h01, 8'h11);
    repeat (MAX_RETRY + 1) expw(7'h3C, 8'h02, 8'h22);
    run(500, el);
    check("t3_nack_slave", 32'({busy, err, done, err_code, err_idx}), {25'd0, 3'b010, 3'd1, 4'd1});
    check("t3_q_empty2", exp_q.size(), 0);

    nack_from = req_n + 1; nack_val = 3'b110;
    expw(7'h3C, 8'h01, 8'h11);
    repeat (MAX_RETRY + 1) expw(7'h3C, 8'h02, 8'h22);
    run(500, el);
    check("t3_nack_addr", 32'({err, err_code, err_idx}), {24'd0, 1'b1, 3'd2, 4'd1});
    nack_cnt = 0;

    // T4: DELAY 5 and DELAY 0 between writes
    clear_tbl();
    tbl[0] = ent(2'b01, 7'h3C, 8'h40, 8'h01);
    tbl[1] = ent(2'b11, 7'h00, 8'h00, 8'h05);
    tbl[2] = ent(2'b01, 7'h3C, 8'h41, 8'h02);
    expw(7'h3C, 8'h40, 8'h01);
    expw(7'h3C, 8'h41, 8'h02);
    run(300, el);
    check("t4_dly5_done", 32'({busy, err, done}), 32'b001);
    check("t4_dly5_gap", 32'(gaps[1] >= B2B + 2 + 5 * DELAY_UNIT - 1 &&
                             gaps[1] <= B2B + 2 + 5 * DELAY_UNIT + 1), 32'd1);
    gaps.delete();
    tbl[1] = ent(2'b11, 7'h00, 8'h00, 8'h00);
    expw(7'h3C, 8'h40, 8'h01);
    expw(7'h3C, 8'h41, 8'h02);
    run(300, el);
    check("t4_dly0_gap", gaps[1], B2B + 2);

    // T5: master never busy -> ack timeout; reserved bits -> bad op
    clear_tbl();
    tbl[0] = ent(2'b01, 7'h3C, 8'h50, 8'h00);
    no_busy = 1'b1;
    run(600, el);
    no_busy = 1'b0;
    check("t5_tmo_code", 32'({err, err_code, err_idx}), {24'd0, 1'b1, 3'd5, 4'd0});
    check("t5_tmo_time", 32'(el >= ACK_TMO && el <= ACK_TMO + 7), 32'd1);
    tbl[1] = ent(2'b01, 7'h3C, 8'h51, 8'h00) | 32'h0080_0000;
    expw(7'h3C, 8'h50, 8'h00);
    run(300, el);
    check("t5_bad_op", 32'({err, err_code, err_idx}), {24'd0, 1'b1, 3'd6, 4'd1});

    // T6a: async reset while waiting on the master
    clear_tbl();
    tbl[0] = ent(2'b01, 7'h3C, 8'h60, 8'hC3);
    blen = 40;
    expw(7'h3C, 8'h60, 8'hC3);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_busy) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("t6_busy_before", 32'({busy, m_busy}), 32'b11);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_ctl", 32'({busy, done, err, err_code, err_idx, tbl_addr, m_wr, m_rd}), 32'd0);
    check("t6_rst_bus", 32'({m_slave, m_reg, m_wdata}), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    blen = 6;
    repeat (2) @(negedge clk);

    // T6b: start pulse mid-run is ignored
    clear_tbl();
    tbl[0] = ent(2'b01, 7'h3C, 8'h70, 8'h01);
    tbl[1] = ent(2'b01, 7'h3C, 8'h71, 8'h02);
    expw(7'h3C, 8'h70, 8'h01);
    expw(7'h3C, 8'h71, 8'h02);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("t6_restart_ign", 32'({busy, err, done}), 32'b001);
    check("t6_q_empty", exp_q.size(), 0);

    // T6c: full table without END
    clear_tbl();
    for (int i = 0; i < 16; i++) begin
      tbl[i] = ent(2'b01, 7'h3C, 8'(i), 8'(i) ^ 8'h5A);
      expw(7'h3C, 8'(i), 8'(i) ^ 8'h5A);
    end
    run(1000, el);
    check("t6_full_done", 32'({busy, err, done}), 32'b001);
    check("t6_no_wrap", 32'(tbl_addr), 32'd15);
    check("t6_full_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
